restoring_div_4bit: RTL and testbench
=====================================

Name: restoring_div_4bit

Overview:
Multi-cycle unsigned restoring divider, one quotient bit per clock. It is the inverse-operation companion to the add/subtract datapath, and each step is one trial subtraction of the divisor from the partial remainder. It sits beside the arithmetic unit and is driven by a simple start/done handshake.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits; legal values are 2 to 16.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a division; accepted only when busy=0.
dividend  input  WIDTH  numerator; sampled on the accepting edge.
divisor  input  WIDTH  denominator; sampled on the accepting edge.
busy  output  1  high while a division is in progress.
done  output  1  one-cycle pulse when results become valid.
quotient  output  WIDTH  result quotient; held until the next accepted start.
remainder  output  WIDTH  result remainder; held until the next accepted start.
dbz  output  1  divide-by-zero flag for the held result.
v  output  1  signed overflow flag; constant 0 unless SIGNED_DIV_EN is defined.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, dbz and v are 0; quotient and remainder are 0; the internal step counter is 0.
- FSM states are IDLE, CALC and DONE.
- IDLE or DONE with start=1 (edge E0):
  - latch the operands;
  - set the partial remainder R (WIDTH+1 bits) to 0;
  - load the shift register Q with the dividend;
  - set busy=1 and clear dbz and v;
  - go to CALC.
  - If the latched divisor is 0, go to CALC anyway; it is resolved at E1.
- CALC, one step per edge (E1..E_WIDTH):
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {0, divisor};
  - if T[WIDTH]=0: R=T and the new Q lsb is 1; otherwise R is restored to the shifted value and the new Q lsb is 0;
  - Q shifts left by one each step.
- After the step at E_WIDTH:
  - register quotient=Q and remainder=R[WIDTH-1:0];
  - done=1, busy=0, go to DONE.
  - Latency from the accepting edge to done visible is exactly WIDTH cycles.
- Divide by zero, decided at E1:
  - quotient=all ones, remainder=dividend, dbz=1, done=1, busy=0, go to DONE.
  - Latency is 1 cycle.
- DONE state:
  - done falls after one cycle;
  - with start=0, return to IDLE;
  - with start=1, accept a new operation in that same edge, as from IDLE.
- start while busy=1 is ignored. The operands are not resampled and the in-flight result is unaffected.
- Outputs hold their last result through IDLE. They change only when done pulses, or on reset.
- Reset asserted mid-CALC aborts immediately to the reset values. No done pulse follows.
- Operand changes after the accepting edge have no effect.
- Invariant for unsigned results: dividend = quotient*divisor + remainder, and remainder < divisor.

Optional Feature:
SIGNED_DIV_EN
- Defined: operands are two's complement.
  - Magnitudes are taken at latch time; the core is the same unsigned core.
  - Signs are fixed before registering the result: the quotient truncates toward zero and the remainder takes the dividend's sign.
  - Latency is unchanged.
  - Most-negative divided by -1: quotient=most-negative, remainder=0, v=1.
  - Divide by zero: quotient=all ones, remainder=dividend, dbz=1.
- Not defined: unsigned operation as above, and v is tied to 0.

Test Plan:
- Reset, then 13/3 with start pulsed 1 cycle: done exactly 4 cycles later, quotient=4, remainder=1, dbz=0; busy high for cycles 1-4.
- 7/0: done 1 cycle after the accept, quotient=15, remainder=7, dbz=1, busy=0.
- Start 15/1, and re-pulse start with 2/2 at cycle 2: the second request is ignored; result quotient=15, remainder=0. Then start held high through DONE: back-to-back 9/4 gives quotient=2, remainder=1.
- Start 12/5 and assert rst_n=0 at cycle 2: all outputs are 0 immediately and no done pulse follows. Then 12/5 completes with quotient=2, remainder=2.
- Exhaustive 256-pair sweep of unsigned operands: every nonzero divisor satisfies the invariant; every zero divisor sets dbz=1.
- With SIGNED_DIV_EN defined, run three cases:
  - -7/2: quotient=-3 (1101), remainder=-1 (1111);
  - 7/-2: quotient=-3, remainder=1;
  - -8/-1: quotient=-8 (1000), remainder=0, v=1.

Source files
------------

// File: rtl/restoring_div_4bit.sv
// Multi-cycle restoring divider: one quotient bit per clock behind a start/done handshake.
// Define SIGNED_DIV_EN for two's complement operands; otherwise unsigned and v is tied to 0.
module restoring_div_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             v
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] divMag_q;
  logic [WIDTH-1:0] dividend_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] remNext_d;
  logic [WIDTH-1:0] shiftNext_d;
  logic [WIDTH-1:0] dividendMag_d;
  logic [WIDTH-1:0] divisorMag_d;
  logic [WIDTH-1:0] finalQuo_d;
  logic [WIDTH-1:0] finalRem_d;
  logic             ovf_d;

`ifdef SIGNED_DIV_EN
  logic negQuot_q;
  logic negRem_q;
  logic ovf_q;
`endif

  // Trial subtraction; the remainder never needs more than WIDTH bits once a step settles.
  always_comb begin
    shifted_d = {rem_q, shift_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, divMag_q};
    if (!trial_d[WIDTH]) begin
      remNext_d   = trial_d[WIDTH-1:0];
      shiftNext_d = {shift_q[WIDTH-2:0], 1'b1};
    end else begin
      remNext_d   = shifted_d[WIDTH-1:0];
      shiftNext_d = {shift_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
`ifdef SIGNED_DIV_EN
    dividendMag_d = dividend[WIDTH-1] ? -dividend : dividend;
    divisorMag_d  = divisor[WIDTH-1]  ? -divisor  : divisor;
    finalQuo_d    = negQuot_q ? -shiftNext_d : shiftNext_d;
    finalRem_d    = negRem_q  ? -remNext_d   : remNext_d;
    ovf_d         = ovf_q;
`else
    dividendMag_d = dividend;
    divisorMag_d  = divisor;
    finalQuo_d    = shiftNext_d;
    finalRem_d    = remNext_d;
    ovf_d         = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      shift_q    <= '0;
      divMag_q   <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      dbz        <= 1'b0;
      v          <= 1'b0;
`ifdef SIGNED_DIV_EN
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dividend_q <= dividend;
            divMag_q   <= divisorMag_d;
            shift_q    <= dividendMag_d;
            rem_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b1;
            dbz        <= 1'b0;
            v          <= 1'b0;
            state_q    <= CALC;
`ifdef SIGNED_DIV_EN
            negQuot_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negRem_q   <= dividend[WIDTH-1];
            ovf_q      <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif
          end else if (state_q == DONE) begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          // A zero divisor is resolved on the first step instead of running the full sweep.
          if (cnt_q == '0 && divMag_q == '0) begin
            quotient  <= '1;
            remainder <= dividend_q;
            dbz       <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= DONE;
          end else begin
            rem_q   <= remNext_d;
            shift_q <= shiftNext_d;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              quotient  <= finalQuo_d;
              remainder <= finalRem_d;
              v         <= ovf_d;
              done      <= 1'b1;
              busy      <= 1'b0;
              cnt_q     <= '0;
              state_q   <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_4bit.sv
// Self-checking bench for restoring_div_4bit: directed handshake cases plus an
// exhaustive sweep and random operations against an arithmetic reference model.
module tb_restoring_div_4bit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       dbz;
   logic       v;

   int total;
   int bad;

   restoring_div_4bit #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quotient (quotient),
      .remainder(remainder),
      .dbz      (dbz),
      .v        (v)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference result from plain integer arithmetic for the current build mode.
   function automatic void refModel(input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] q, output logic [3:0] r,
                                    output logic z, output logic ov);
      int sa;
      int sb;
      int sq;
      int sr;
      ov = 1'b0;
      if (b == 4'd0) begin
         q = 4'hF;
         r = a;
         z = 1'b1;
      end else begin
         z = 1'b0;
`ifdef SIGNED_DIV_EN
         sa = {{28{a[3]}}, a};
         sb = {{28{b[3]}}, b};
         ov = (sa == -8) && (sb == -1);
`else
         sa = {28'd0, a};
         sb = {28'd0, b};
`endif
         sq = sa / sb;
         sr = sa % sb;
         q = sq[3:0];
         r = sr[3:0];
      end
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one operation, scramble operands while it runs, return the result.
   task automatic runOp(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic z, output logic ov,
                        output int lat, output logic timedOut);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      lat      = 0;
      timedOut = 1'b0;
      while (done !== 1'b1 && !timedOut) begin
         dividend = 4'($urandom);
         divisor  = 4'($urandom);
         tick();
         lat++;
         if (lat >= 40) timedOut = 1'b1;
      end
      q  = quotient;
      r  = remainder;
      z  = dbz;
      ov = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      dividend = 4'd0;
      divisor = 4'd0;
      #12;
      total++;
      if ({busy, done, dbz, v} !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, dbz, v});
      end
      total++;
      if ({quotient, remainder} !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_results: got %h expected 00", {quotient, remainder});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [3:0] eq, er;
      logic ez, ev;
      refModel(4'd13, 4'd3, eq, er, ez, ev);
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_busy c%0d: got busy=%b done=%b expected busy=1 done=0", c, busy, done);
         end
         if (c < 4) tick();
      end
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
      end
      total++;
      if (quotient !== eq || remainder !== er || dbz !== ez) begin
         bad++;
         $display("[TB] FAIL basic_result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                  quotient, remainder, dbz, eq, er, ez);
      end
      tick();
      total++;
      if (done !== 1'b0 || quotient !== eq) begin
         bad++;
         $display("[TB] FAIL basic_pulse: got done=%b q=%h expected done=0 q=%h", done, quotient, eq);
      end
   endtask

   task automatic test_dbz();
      dividend = 4'd7;
      divisor  = 4'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || dbz !== 1'b1) begin
         bad++;
         $display("[TB] FAIL dbz_flags: got done=%b busy=%b dbz=%b expected 1 0 1", done, busy, dbz);
      end
      total++;
      if (quotient !== 4'hF || remainder !== 4'd7) begin
         bad++;
         $display("[TB] FAIL dbz_result: got q=%h r=%h expected q=f r=7", quotient, remainder);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] eq, er;
      logic ez, ev;
      int lat;
      refModel(4'd15, 4'd1, eq, er, ez, ev);
      dividend = 4'd15;
      divisor  = 4'd1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      tick();
      dividend = 4'd2;
      divisor  = 4'd2;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      lat = 2;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      total++;
      if (lat !== 4 || quotient !== eq || remainder !== er) begin
         bad++;
         $display("[TB] FAIL ignore_start: got lat=%0d q=%h r=%h expected lat=4 q=%h r=%h",
                  lat, quotient, remainder, eq, er);
      end
      refModel(4'd9, 4'd4, eq, er, ez, ev);
      dividend = 4'd9;
      divisor  = 4'd4;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      total++;
      if (lat !== 4 || quotient !== eq || remainder !== er || dbz !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_result: got lat=%0d q=%h r=%h dbz=%b expected lat=4 q=%h r=%h dbz=0",
                  lat, quotient, remainder, dbz, eq, er);
      end
   endtask

   task automatic test_reset_abort();
      logic [3:0] q, r, eq, er;
      logic z, ov, ez, ev, to, sawDone;
      int lat;
      dividend = 4'd12;
      divisor  = 4'd5;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, dbz, v} !== 4'b0000 || {quotient, remainder} !== 8'h00) begin
         bad++;
         $display("[TB] FAIL abort_clear: got flags=%b q=%h r=%h expected 0000 0 0",
                  {busy, done, dbz, v}, quotient, remainder);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sawDone = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
      end
      total++;
      if (sawDone !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_no_done: got activity=%b expected 0", sawDone);
      end
      refModel(4'd12, 4'd5, eq, er, ez, ev);
      runOp(4'd12, 4'd5, q, r, z, ov, lat, to);
      total++;
      if (to || lat !== 4 || q !== eq || r !== er) begin
         bad++;
         $display("[TB] FAIL abort_rerun: got lat=%0d q=%h r=%h expected lat=4 q=%h r=%h", lat, q, r, eq, er);
      end
   endtask

   task automatic test_sweep();
      logic [3:0] q, r, eq, er;
      logic z, ov, ez, ev, to;
      int lat;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            refModel(4'(a), 4'(b), eq, er, ez, ev);
            runOp(4'(a), 4'(b), q, r, z, ov, lat, to);
            total++;
            if (to || lat !== (b == 0 ? 1 : 4) || q !== eq || r !== er || z !== ez || ov !== ev) begin
               bad++;
               $display("[TB] FAIL sweep %0d/%0d: got lat=%0d q=%h r=%h dbz=%b v=%b expected q=%h r=%h dbz=%b v=%b",
                        a, b, lat, q, r, z, ov, eq, er, ez, ev);
            end
`ifndef SIGNED_DIV_EN
            if (b != 0) begin
               total++;
               if (int'(q) * b + int'(r) != a || int'(r) >= b) begin
                  bad++;
                  $display("[TB] FAIL invariant %0d/%0d: got q=%0d r=%0d", a, b, q, r);
               end
            end
`endif
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] a, b, q, r, eq, er;
      logic z, ov, ez, ev, to;
      int lat;
      for (int i = 0; i < 40; i++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         refModel(a, b, eq, er, ez, ev);
         runOp(a, b, q, r, z, ov, lat, to);
         total++;
         if (to || q !== eq || r !== er || z !== ez || ov !== ev) begin
            bad++;
            $display("[TB] FAIL random %h/%h: got q=%h r=%h dbz=%b v=%b expected q=%h r=%h dbz=%b v=%b",
                     a, b, q, r, z, ov, eq, er, ez, ev);
         end
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      end
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed();
      logic [3:0] q, r;
      logic z, ov, to;
      int lat;
      runOp(4'b1001, 4'b0010, q, r, z, ov, lat, to);
      total++;
      if (to || q !== 4'b1101 || r !== 4'b1111 || ov !== 1'b0) begin
         bad++;
         $display("[TB] FAIL signed_m7_2: got q=%b r=%b v=%b expected q=1101 r=1111 v=0", q, r, ov);
      end
      runOp(4'b0111, 4'b1110, q, r, z, ov, lat, to);
      total++;
      if (to || q !== 4'b1101 || r !== 4'b0001 || ov !== 1'b0) begin
         bad++;
         $display("[TB] FAIL signed_7_m2: got q=%b r=%b v=%b expected q=1101 r=0001 v=0", q, r, ov);
      end
      runOp(4'b1000, 4'b1111, q, r, z, ov, lat, to);
      total++;
      if (to || lat !== 4 || q !== 4'b1000 || r !== 4'b0000 || ov !== 1'b1) begin
         bad++;
         $display("[TB] FAIL signed_ovf: got lat=%0d q=%b r=%b v=%b expected lat=4 q=1000 r=0000 v=1", lat, q, r, ov);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_dbz();
      test_back_to_back();
      test_reset_abort();
`ifdef SIGNED_DIV_EN
      test_signed();
`endif
      test_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
